vga_capture: RTL and testbench

Frame-buffer writer for the video path: samples a 640x480 VGA-timed stream (12-bit RGB, active-low HSYNC/VSYNC, one pixel per clk) and writes the active window into the same 19-bit-addressed frame memory the VGA output stage reads. It locks onto incoming sync before writing and issues a one-cycle frame-start pulse, so the output stage can be re-aligned via its SyncVsync input.

---
 rtl/vga_capture.sv | 241 ++++++++++++++++++++++++
 tb/tb_vga_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_capture
// Purpose  : Locks onto a VGA-timed 12-bit RGB stream and writes the active
//            window into the 19-bit-addressed frame memory. Emits a frame-start
//            pulse on every VSYNC fall while locked and a sync-error pulse when
//            lock is lost.
// Options  : VGA_CAPTURE_HALFRATE_EN - write every other active pixel
//            (two clocks per stored word); undefined = full rate.
// Revision : 1.0 - initial release
// ============================================================================
module vga_capture #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 521,
   parameter int H_ACT_START = 144,
   parameter int H_ACT       = 640,
   parameter int V_ACT_START = 31,
   parameter int V_ACT       = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HSYNC,
   input  logic        VSYNC,
   input  logic [3:0]  RED,
   input  logic [3:0]  GRN,
   input  logic [3:0]  BLU,
   output logic [18:0] WriteAdd,
   output logic [11:0] WriteData,
   output logic        WriteEn,
   output logic        FrameStart,
   output logic        Locked,
   output logic        SyncErr
);

   // Counter comparison points, all in the 10-bit counter domain
   localparam logic [9:0] c_H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] c_H_START   = 10'(H_ACT_START);
   localparam logic [9:0] c_H_END     = 10'(H_ACT_START + H_ACT);
   localparam logic [9:0] c_V_START   = 10'(V_ACT_START);
   localparam logic [9:0] c_V_END     = 10'(V_ACT_START + V_ACT);
   localparam logic [9:0] c_HCNT_SAT  = 10'h3FF;
`ifdef VGA_CAPTURE_HALFRATE_EN
   localparam int         c_WORDS     = (H_ACT / 2) * V_ACT;
`else
   localparam int         c_WORDS     = H_ACT * V_ACT;
`endif
   localparam logic [18:0] c_ADDR_MAX = 19'(c_WORDS - 1);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   // Stage 1 and edge-detect history
   logic        r_hs;
   logic        r_vs;
   logic        r_hs_prev;
   logic        r_vs_prev;
   logic [11:0] r_rgb;

   // Timing counters and capture control
   logic [9:0]  r_hcnt;
   logic [9:0]  r_vcnt;
   logic [18:0] r_ptr;
   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_bad_seen;
   logic        w_bad_seen_nxt;

   // Stage 2 output registers
   logic [18:0] r_write_add;
   logic [11:0] r_write_data;
   logic        r_write_en;
   logic        r_frame_start;
   logic        r_locked;
   logic        r_sync_err;

   logic        w_hs_fall;
   logic        w_vs_fall;
   logic        w_bad_line;
   logic        w_bad_frame;
   logic        w_hsat;
   logic        w_frame_start;
   logic        w_sync_err;
   logic        w_in_h;
   logic        w_in_v;
   logic        w_pix_sel;
   logic        w_active;
   logic        w_write;

   // Register raw sync and colour; idle (high) sync after reset so the first
   // real falling edge is seen as an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hs      <= 1'b1;
         r_vs      <= 1'b1;
         r_hs_prev <= 1'b1;
         r_vs_prev <= 1'b1;
         r_rgb     <= 12'd0;
      end else begin
         r_hs      <= HSYNC;
         r_vs      <= VSYNC;
         r_hs_prev <= r_hs;
         r_vs_prev <= r_vs;
         r_rgb     <= {BLU, GRN, RED};
      end
   end

   assign w_hs_fall   = r_hs_prev & ~r_hs;
   assign w_vs_fall   = r_vs_prev & ~r_vs;
   // Both checks look at the counts as they stand before this edge clears them
   assign w_bad_line  = w_hs_fall && (r_hcnt != c_H_LAST);
   assign w_bad_frame = w_vs_fall && (r_vcnt != c_V_LAST);
   assign w_hsat      = (r_hcnt == c_HCNT_SAT);

   // Pixel and line counters; VSYNC clear wins over the line increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hcnt <= 10'd0;
         r_vcnt <= 10'd0;
      end else begin
         if (w_hs_fall) begin
            r_hcnt <= 10'd0;
         end else if (!w_hsat) begin
            r_hcnt <= r_hcnt + 10'd1;
         end
         if (w_vs_fall) begin
            r_vcnt <= 10'd0;
         end else if (w_hs_fall) begin
            r_vcnt <= r_vcnt + 10'd1;
         end
      end
   end

   // Lock state register and the "bad line seen while armed" flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_SEARCH;
         r_bad_seen <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bad_seen <= w_bad_seen_nxt;
      end
   end

   // Lock sequencing: SEARCH -> ARMED on any VSYNC fall, ARMED -> CAPTURE
   // after one clean frame, CAPTURE -> SEARCH on any timing violation.
   always_comb begin
      w_state_nxt    = r_state;
      w_bad_seen_nxt = r_bad_seen;
      w_frame_start  = 1'b0;
      w_sync_err     = 1'b0;
      case (r_state)
         S_SEARCH: begin
            if (w_vs_fall) begin
               w_state_nxt    = S_ARMED;
               w_bad_seen_nxt = 1'b0;
            end
         end
         S_ARMED: begin
            if (w_vs_fall) begin
               if (!w_bad_frame && !w_bad_line && !w_hsat && !r_bad_seen) begin
                  w_state_nxt   = S_CAPTURE;
                  w_frame_start = 1'b1;
               end
               // Either way a new observation frame starts here
               w_bad_seen_nxt = 1'b0;
            end else if (w_bad_line || w_hsat) begin
               w_bad_seen_nxt = 1'b1;
            end
         end
         S_CAPTURE: begin
            if (w_bad_line || w_bad_frame || w_hsat) begin
               w_state_nxt = S_SEARCH;
               w_sync_err  = 1'b1;
            end else if (w_vs_fall) begin
               w_frame_start = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_SEARCH;
         end
      endcase
   end

   assign w_in_h = (r_hcnt >= c_H_START) && (r_hcnt < c_H_END);
   assign w_in_v = (r_vcnt >= c_V_START) && (r_vcnt < c_V_END);
`ifdef VGA_CAPTURE_HALFRATE_EN
   // Even offset from the first active pixel <=> same LSB as the start count
   assign w_pix_sel = (r_hcnt[0] == c_H_START[0]);
`else
   assign w_pix_sel = 1'b1;
`endif
   // An error detected this cycle already blocks the write it coincides with
   assign w_active = (r_state == S_CAPTURE) && !w_sync_err && w_in_h && w_in_v && w_pix_sel;
   assign w_write  = w_active && (r_ptr <= c_ADDR_MAX);

   // Write pointer: restarts every frame, stops at the top of the buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 19'd0;
      end else if (w_vs_fall) begin
         r_ptr <= 19'd0;
      end else if (w_write) begin
         r_ptr <= r_ptr + 19'd1;
      end
   end

   // Stage 2: memory write port and status pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write_add   <= 19'd0;
         r_write_data  <= 12'd0;
         r_write_en    <= 1'b0;
         r_frame_start <= 1'b0;
         r_locked      <= 1'b0;
         r_sync_err    <= 1'b0;
      end else begin
         r_write_en    <= w_write;
         if (w_write) begin
            r_write_add  <= r_ptr;
            r_write_data <= r_rgb;
         end
         r_frame_start <= w_frame_start;
         r_sync_err    <= w_sync_err;
         r_locked      <= (w_state_nxt == S_CAPTURE);
      end
   end

   assign WriteAdd   = r_write_add;
   assign WriteData  = r_write_data;
   assign WriteEn    = r_write_en;
   assign FrameStart = r_frame_start;
   assign Locked     = r_locked;
   assign SyncErr    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_capture
// Purpose  : Scoreboard bench for vga_capture using a reduced raster so whole
//            frames fit in a short run. Honours VGA_CAPTURE_HALFRATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_capture;

   localparam int H_TOTAL     = 40;
   localparam int V_TOTAL     = 16;
   localparam int H_ACT_START = 10;
   localparam int H_ACT       = 20;
   localparam int V_ACT_START = 3;
   localparam int V_ACT       = 10;
   localparam int HS_W        = 4;
   localparam int VS_LINES    = 2;
`ifdef VGA_CAPTURE_HALFRATE_EN
   localparam bit HALF        = 1'b1;
   localparam int WORDS       = (H_ACT / 2) * V_ACT;
`else
   localparam bit HALF        = 1'b0;
   localparam int WORDS       = H_ACT * V_ACT;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        HSYNC = 1'b1;
   logic        VSYNC = 1'b1;
   logic [3:0]  RED = 4'd0;
   logic [3:0]  GRN = 4'd0;
   logic [3:0]  BLU = 4'd0;
   logic [18:0] WriteAdd;
   logic [11:0] WriteData;
   logic        WriteEn;
   logic        FrameStart;
   logic        Locked;
   logic        SyncErr;

   typedef struct {
      logic [18:0] a;
      logic [11:0] d;
      int          t;
   } wr_t;

   wr_t wq[$];
   int  fsq[$];
   int  erq[$];
   int  checks = 0;
   int  errors = 0;
   int  n_wr   = 0;
   int  cyc    = 0;

   vga_capture #(
      .H_TOTAL     (H_TOTAL),
      .V_TOTAL     (V_TOTAL),
      .H_ACT_START (H_ACT_START),
      .H_ACT       (H_ACT),
      .V_ACT_START (V_ACT_START),
      .V_ACT       (V_ACT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .HSYNC      (HSYNC),
      .VSYNC      (VSYNC),
      .RED        (RED),
      .GRN        (GRN),
      .BLU        (BLU),
      .WriteAdd   (WriteAdd),
      .WriteData  (WriteData),
      .WriteEn    (WriteEn),
      .FrameStart (FrameStart),
      .Locked     (Locked),
      .SyncErr    (SyncErr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every write and every pulse
   always @(negedge clk) begin
      wr_t e;
      if (!rst) begin
         if (WriteEn) begin
            checks++;
            if (wq.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected cycle %0d addr %0d data %h, required no write", cyc, WriteAdd, WriteData);
            end else begin
               e = wq.pop_front();
               n_wr++;
               if (WriteAdd !== e.a || WriteData !== e.d || cyc != e.t) begin
                  errors++;
                  $display("FAIL write got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                           WriteAdd, WriteData, cyc, e.a, e.d, e.t);
               end
            end
         end
         if (FrameStart) begin
            checks++;
            if (fsq.size() > 0 && fsq[0] == cyc) begin
               void'(fsq.pop_front());
            end else begin
               errors++;
               $display("FAIL framestart got pulse at cycle %0d, required %0d", cyc, (fsq.size() > 0) ? fsq[0] : -1);
            end
         end
         if (fsq.size() > 0 && fsq[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL framestart_missed got none, required pulse at cycle %0d", fsq[0]);
            void'(fsq.pop_front());
         end
         if (SyncErr) begin
            checks++;
            if (erq.size() > 0 && erq[0] == cyc) begin
               void'(erq.pop_front());
            end else begin
               errors++;
               $display("FAIL syncerr got pulse at cycle %0d, required %0d", cyc, (erq.size() > 0) ? erq[0] : -1);
            end
         end
         if (erq.size() > 0 && erq[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL syncerr_missed got none, required pulse at cycle %0d", erq[0]);
            void'(erq.pop_front());
         end
      end
   end

   task automatic drive_cycle(input bit hs, input bit vs, input logic [11:0] pix);
      @(posedge clk);
      #1;
      HSYNC = hs;
      VSYNC = vs;
      {BLU, GRN, RED} = pix;
   endtask

   // One raster line; k=0 is the HSYNC fall, the pixel driven at k has hcnt k-1
   task automatic drive_line(input int y, input int len, input bit vs_lo, input bit cap,
                             input bit fs_here, input bit err_here);
      logic [11:0] pix;
      int          x;
      int          yy;
      int          addr;
      for (int k = 0; k < len; k++) begin
         x  = k - 1 - H_ACT_START;
         yy = y - V_ACT_START;
         pix = 12'($urandom);
         if (x == 0 && yy == 0) pix = 12'h321;
         drive_cycle(k >= HS_W, !vs_lo, pix);
         if (k == 0 && fs_here)  fsq.push_back(cyc + 2);
         if (k == 0 && err_here) erq.push_back(cyc + 2);
         if (cap && x >= 0 && x < H_ACT && yy >= 0 && yy < V_ACT && (!HALF || (x % 2) == 0)) begin
            addr = HALF ? (yy * (H_ACT / 2) + x / 2) : (yy * H_ACT + x);
            wq.push_back('{a: 19'(addr), d: pix, t: cyc + 2});
         end
      end
   endtask

   // A frame starting with a coincident HSYNC/VSYNC fall; bad_y gets a short line
   task automatic drive_frame(input int nlines, input int bad_y, input bit cap,
                              input bit exp_fs, input bit exp_err);
      bit alive;
      bit err_here;
      alive = cap;
      for (int y = 0; y < nlines; y++) begin
         err_here = (y == 0 && exp_err);
         if (bad_y >= 0 && y == bad_y + 1 && alive) begin
            err_here = 1'b1;
            alive    = 1'b0;
         end
         drive_line(y, (y == bad_y) ? H_TOTAL - 1 : H_TOTAL, y < VS_LINES, alive,
                    y == 0 && exp_fs, err_here);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({WriteAdd, WriteData, WriteEn, FrameStart, Locked, SyncErr} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h, required 0",
                  {WriteAdd, WriteData, WriteEn, FrameStart, Locked, SyncErr});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) drive_cycle(1'b1, 1'b1, 12'd0);
   endtask

   task automatic test_lock;
      int n0;
      drive_frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (Locked !== 1'b0) begin
         errors++;
         $display("FAIL lock_first_fall got Locked %b, required 0", Locked);
      end
      n0 = n_wr;
      drive_frame(V_TOTAL, -1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (Locked !== 1'b1) begin
         errors++;
         $display("FAIL lock_second_fall got Locked %b, required 1", Locked);
      end
      checks++;
      if (n_wr - n0 != WORDS) begin
         errors++;
         $display("FAIL lock_word_count got %0d, required %0d", n_wr - n0, WORDS);
      end
   endtask

   task automatic test_line_error;
      drive_frame(V_TOTAL, 5, 1'b1, 1'b1, 1'b0);
      checks++;
      if (Locked !== 1'b0) begin
         errors++;
         $display("FAIL line_err_locked got %b, required 0", Locked);
      end
      drive_frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (Locked !== 1'b0) begin
         errors++;
         $display("FAIL line_err_armed got %b, required 0", Locked);
      end
      drive_frame(V_TOTAL, -1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (Locked !== 1'b1) begin
         errors++;
         $display("FAIL line_err_relock got %b, required 1", Locked);
      end
   endtask

   task automatic test_frame_error;
      drive_frame(V_TOTAL - 1, -1, 1'b1, 1'b1, 1'b0);
      drive_frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (Locked !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_locked got %b, required 0", Locked);
      end
      drive_frame(V_TOTAL - 1, -1, 1'b0, 1'b0, 1'b0);
      drive_frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (Locked !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_armed_bad got %b, required 0", Locked);
      end
      drive_frame(V_TOTAL, -1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (Locked !== 1'b1) begin
         errors++;
         $display("FAIL frame_err_relock got %b, required 1", Locked);
      end
   endtask

   task automatic test_coincident;
      int n0;
      n0 = n_wr;
      drive_frame(V_TOTAL, -1, 1'b1, 1'b1, 1'b0);
      drive_frame(V_TOTAL, -1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (Locked !== 1'b1) begin
         errors++;
         $display("FAIL coincident_locked got %b, required 1", Locked);
      end
      checks++;
      if (n_wr - n0 != 2 * WORDS) begin
         errors++;
         $display("FAIL coincident_word_count got %0d, required %0d", n_wr - n0, 2 * WORDS);
      end
   endtask

   task automatic test_reset_midline;
      for (int y = 0; y < 5; y++) begin
         drive_line(y, H_TOTAL, y < VS_LINES, 1'b1, y == 0, 1'b0);
      end
      drive_line(5, H_ACT_START + 8, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      checks++;
      if (WriteEn !== 1'b1) begin
         errors++;
         $display("FAIL midline_pre_reset_wren got %b, required 1", WriteEn);
      end
      rst   = 1'b1;
      HSYNC = 1'b1;
      VSYNC = 1'b1;
      #1;
      checks++;
      if ({WriteAdd, WriteData, WriteEn, FrameStart, Locked, SyncErr} !== 35'd0) begin
         errors++;
         $display("FAIL midline_reset_outputs got %h, required 0",
                  {WriteAdd, WriteData, WriteEn, FrameStart, Locked, SyncErr});
      end
      wq.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) drive_cycle(1'b1, 1'b1, 12'd0);
      drive_frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (Locked !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_first_fall got %b, required 0", Locked);
      end
      drive_frame(V_TOTAL, -1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (Locked !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_relock got %b, required 1", Locked);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_line_error();
      test_frame_error();
      test_coincident();
      test_reset_midline();
      repeat (6) drive_cycle(1'b1, 1'b1, 12'd0);
      @(negedge clk);
      checks++;
      if (wq.size() != 0 || fsq.size() != 0 || erq.size() != 0) begin
         errors++;
         $display("FAIL drain got pending writes %0d framestarts %0d syncerrs %0d, required 0 0 0",
                  wq.size(), fsq.size(), erq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
